hazard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage RISC-V core: it replaces the forwarding-only hazard logic. It provides EX-stage operand forwarding for N_SRC source operands and detects load-use hazards. It also adds a scoreboard for one in-flight fixed-latency multi-cycle unit (MUL/DIV), with RAW stalls, a reserved writeback slot, branch flush control and a sticky protocol-error flag.

---
 rtl/hazard_pkg.sv | 15 +
 rtl/hazard_ctrl_if.sv | 47 ++++
 rtl/md_scoreboard.sv | 71 +++++++
 rtl/hazard_ctrl.sv | 84 ++++++++
 tb/tb_hazard_ctrl.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared codes and defaults for the hazard controller
// Purpose: forward-select codes, register index width default, scoreboard counter width.
// Ports: none (package).
package hazard_pkg;

    localparam int REG_AW_DEF = 5;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline <-> hazard controller signal bundle
// Purpose: groups pipeline stage indices/enables and hazard decisions.
// Ports: master = pipeline side (drives stage info, reads decisions),
//        slave  = hazard controller side.
interface hazard_ctrl_if
    import hazard_pkg::*;
#(
    parameter int N_SRC  = 2,
    parameter int REG_AW = REG_AW_DEF
);
    logic [N_SRC*REG_AW-1:0] rs_d;
    logic                    md_op_d;
    logic [N_SRC*REG_AW-1:0] rs_e;
    logic [REG_AW-1:0]       rd_e;
    logic [REG_AW-1:0]       rd_m;
    logic [REG_AW-1:0]       rd_w;
    logic                    regwrite_m;
    logic                    regwrite_w;
    logic                    memread_e;
    logic                    pcsrc_e;
    logic                    md_start_e;

    logic [2*N_SRC-1:0]      fwd_e;
    logic                    stall_f;
    logic                    stall_d;
    logic                    flush_d;
    logic                    flush_e;
    logic                    md_wb;
    logic [REG_AW-1:0]       md_wb_rd;
    logic                    md_busy;
    logic                    md_err;

    modport master (
        output rs_d, md_op_d, rs_e, rd_e, rd_m, rd_w, regwrite_m, regwrite_w,
               memread_e, pcsrc_e, md_start_e,
        input  fwd_e, stall_f, stall_d, flush_d, flush_e, md_wb, md_wb_rd,
               md_busy, md_err
    );

    modport slave (
        input  rs_d, md_op_d, rs_e, rd_e, rd_m, rd_w, regwrite_m, regwrite_w,
               memread_e, pcsrc_e, md_start_e,
        output fwd_e, stall_f, stall_d, flush_d, flush_e, md_wb, md_wb_rd,
               md_busy, md_err
    );

endinterface

// File: rtl/md_scoreboard.sv
// rtl/md_scoreboard.sv - single-entry scoreboard for the fixed-latency MUL/DIV unit
// Purpose: tracks one in-flight multi-cycle op, flags its writeback cycle and the
//          slot-reservation cycle, and latches a sticky error on overlapping issue.
// Ports: clk, rst (sync, active-high); md_start_i/rd_i issue request from EX;
//        pend_o/dst_o entry state; slot_o (cnt==2); md_wb_o (cnt==0); md_err_o sticky.
module md_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int MD_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              md_start_i,
    input  logic [REG_AW-1:0] rd_i,
    output logic              pend_o,
    output logic [REG_AW-1:0] dst_o,
    output logic              slot_o,
    output logic              md_wb_o,
    output logic              md_err_o
);

    logic              pend_q, pend_d;
    logic [REG_AW-1:0] dst_q,  dst_d;
    logic [CNT_W-1:0]  cnt_q,  cnt_d;
    logic              err_q,  err_d;

    always_comb begin
        pend_d = pend_q;
        dst_d  = dst_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        if (pend_q) begin
            // Entry retires after its writeback cycle; a second issue is dropped.
            if (cnt_q == '0) begin
                pend_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            if (md_start_i) begin
                err_d = 1'b1;
            end
        end else if (md_start_i) begin
            pend_d = 1'b1;
            dst_d  = rd_i;
            cnt_d  = CNT_W'(MD_LAT - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= 1'b0;
            dst_q  <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            dst_q  <= dst_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign pend_o   = pend_q;
    assign dst_o    = dst_q;
    // Stalling two cycles ahead lets the injected bubble occupy WB when cnt hits 0.
    assign slot_o   = pend_q && (cnt_q == CNT_W'(2));
    assign md_wb_o  = pend_q && (cnt_q == '0);
    assign md_err_o = err_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline hazard controller
// Purpose: EX operand forwarding, load-use detection, MUL/DIV RAW/slot stalls
//          and branch flush control; all decisions combinational.
// Ports: clk, rst (sync, active-high, forces every output to 0);
//        hz (hazard_ctrl_if.slave) carrying stage indices in and decisions out.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int N_SRC  = 2,
    parameter int REG_AW = REG_AW_DEF,
    parameter int MD_LAT = 4   // legal 3..15
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);

    logic              pend;
    logic [REG_AW-1:0] dst;
    logic              slot;
    logic              md_wb;
    logic              md_err;

    md_scoreboard #(
        .REG_AW (REG_AW),
        .MD_LAT (MD_LAT)
    ) u_md_sb (
        .clk        (clk),
        .rst        (rst),
        .md_start_i (hz.md_start_e),
        .rd_i       (hz.rd_e),
        .pend_o     (pend),
        .dst_o      (dst),
        .slot_o     (slot),
        .md_wb_o    (md_wb),
        .md_err_o   (md_err)
    );

    logic [2*N_SRC-1:0] fwd;
    logic               lu_hit;
    logic               md_hit;
    logic               lu;
    logic               mds;
    logic               stall;

    always_comb begin
        fwd    = '0;
        lu_hit = 1'b0;
        md_hit = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            // x0 is never forwarded; MEM is the younger producer so it wins.
            if (hz.rs_e[i*REG_AW +: REG_AW] != '0) begin
                if (hz.regwrite_m && (hz.rd_m == hz.rs_e[i*REG_AW +: REG_AW])) begin
                    fwd[2*i +: 2] = FWD_MEM;
                end else if (hz.regwrite_w && (hz.rd_w == hz.rs_e[i*REG_AW +: REG_AW])) begin
                    fwd[2*i +: 2] = FWD_WB;
                end
            end
            if (hz.rs_d[i*REG_AW +: REG_AW] != '0) begin
                if (hz.rd_e == hz.rs_d[i*REG_AW +: REG_AW]) begin
                    lu_hit = 1'b1;
                end
                if (dst == hz.rs_d[i*REG_AW +: REG_AW]) begin
                    md_hit = 1'b1;
                end
            end
        end
        lu    = hz.memread_e && (hz.rd_e != '0) && lu_hit;
        // A new multi-cycle op in D must wait because the unit holds one entry.
        mds   = pend && (hz.md_op_d || ((dst != '0) && md_hit));
        stall = lu || mds || slot;
    end

    assign hz.fwd_e    = rst ? '0   : fwd;
    assign hz.stall_f  = !rst && stall && !hz.pcsrc_e;
    assign hz.stall_d  = !rst && stall && !hz.pcsrc_e;
    assign hz.flush_d  = !rst && hz.pcsrc_e;
    assign hz.flush_e  = !rst && (stall || hz.pcsrc_e);
    assign hz.md_wb    = !rst && md_wb;
    assign hz.md_wb_rd = (!rst && md_wb) ? dst : '0;
    assign hz.md_busy  = !rst && pend;
    assign hz.md_err   = !rst && md_err;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam int N_SRC  = 2;
    localparam int REG_AW = 5;
    localparam int MD_LAT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.N_SRC(N_SRC), .REG_AW(REG_AW)) hif ();

    hazard_ctrl #(.N_SRC(N_SRC), .REG_AW(REG_AW), .MD_LAT(MD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif.slave)
    );

    typedef struct packed {
        logic [4:0] rs_d0;
        logic [4:0] rs_d1;
        logic       md_op;
        logic [4:0] rs_e0;
        logic [4:0] rs_e1;
        logic [4:0] rd_e;
        logic [4:0] rd_m;
        logic       rwm;
        logic [4:0] rd_w;
        logic       rww;
        logic       memrd;
        logic       pcsrc;
        logic       start;
        logic       rst;
    } stim_t;

    logic [15:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    function automatic stim_t S(int rsd0, int rsd1, int mdop, int rse0, int rse1, int rde,
                                int rdm, int rwm, int rdw, int rww, int memrd, int pcsrc,
                                int start, int r);
        stim_t s;
        s.rs_d0 = 5'(rsd0);  s.rs_d1 = 5'(rsd1);  s.md_op = 1'(mdop);
        s.rs_e0 = 5'(rse0);  s.rs_e1 = 5'(rse1);  s.rd_e  = 5'(rde);
        s.rd_m  = 5'(rdm);   s.rwm   = 1'(rwm);   s.rd_w  = 5'(rdw);
        s.rww   = 1'(rww);   s.memrd = 1'(memrd); s.pcsrc = 1'(pcsrc);
        s.start = 1'(start); s.rst   = 1'(r);
        return s;
    endfunction

    // Order: fwd_e[3:0], stall_f, stall_d, flush_d, flush_e, md_wb, md_wb_rd[4:0], md_busy, md_err
    function automatic logic [15:0] E(int fwd, int sf, int sd, int fd, int fe, int wb,
                                      int wbrd, int busy, int err);
        return {4'(fwd), 1'(sf), 1'(sd), 1'(fd), 1'(fe), 1'(wb), 5'(wbrd), 1'(busy), 1'(err)};
    endfunction

    function automatic stim_t IDLE();
        return S(0,0,0, 0,0, 0, 0,0, 0,0, 0,0,0, 0);
    endfunction

    function automatic logic [15:0] obs();
        return {hif.fwd_e, hif.stall_f, hif.stall_d, hif.flush_d, hif.flush_e,
                hif.md_wb, hif.md_wb_rd, hif.md_busy, hif.md_err};
    endfunction

    task automatic apply(input stim_t s);
        rst            = s.rst;
        hif.rs_d       = {s.rs_d1, s.rs_d0};
        hif.md_op_d    = s.md_op;
        hif.rs_e       = {s.rs_e1, s.rs_e0};
        hif.rd_e       = s.rd_e;
        hif.rd_m       = s.rd_m;
        hif.rd_w       = s.rd_w;
        hif.regwrite_m = s.rwm;
        hif.regwrite_w = s.rww;
        hif.memread_e  = s.memrd;
        hif.pcsrc_e    = s.pcsrc;
        hif.md_start_e = s.start;
    endtask

    task automatic test_reset();
        stim_t st[$];
        logic [15:0] ex[$];
        logic [15:0] got, want;
        st.push_back(S(7,0,1, 5,0, 7, 5,1, 5,1, 1,1,1, 1)); ex.push_back(E(0,0,0,0,0,0,0,0,0));
        st.push_back(S(7,0,1, 5,0, 7, 5,1, 5,1, 1,1,1, 1)); ex.push_back(E(0,0,0,0,0,0,0,0,0));
        st.push_back(IDLE());                               ex.push_back(E(0,0,0,0,0,0,0,0,0));
        st.push_back(IDLE());                               ex.push_back(E(0,0,0,0,0,0,0,0,0));
        for (int k = 0; k < st.size(); k++) begin
            @(negedge clk); apply(st[k]); exp_q.push_back(ex[k]); #2;
            got = obs(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) $display("FAIL reset[%0d]: got %h want %h", k, got, want);
            else n_pass++;
        end
    endtask

    task automatic test_forward();
        stim_t st[$];
        logic [15:0] ex[$];
        logic [15:0] got, want;
        st.push_back(S(0,0,0, 5,3, 0, 5,1, 5,1, 0,0,0, 0)); ex.push_back(E(4'b0010,0,0,0,0,0,0,0,0));
        st.push_back(S(0,0,0, 0,5, 0, 5,1, 5,1, 0,0,0, 0)); ex.push_back(E(4'b1000,0,0,0,0,0,0,0,0));
        st.push_back(S(0,0,0, 5,6, 0, 5,0, 5,1, 0,0,0, 0)); ex.push_back(E(4'b0001,0,0,0,0,0,0,0,0));
        st.push_back(S(0,0,0, 6,6, 0, 6,1, 6,1, 0,0,0, 0)); ex.push_back(E(4'b1010,0,0,0,0,0,0,0,0));
        st.push_back(S(0,0,0, 7,8, 0, 8,1, 7,1, 0,0,0, 0)); ex.push_back(E(4'b1001,0,0,0,0,0,0,0,0));
        st.push_back(S(0,0,0, 0,9, 0, 0,1, 9,0, 0,0,0, 0)); ex.push_back(E(4'b0000,0,0,0,0,0,0,0,0));
        for (int k = 0; k < st.size(); k++) begin
            @(negedge clk); apply(st[k]); exp_q.push_back(ex[k]); #2;
            got = obs(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) $display("FAIL forward[%0d]: got %h want %h", k, got, want);
            else n_pass++;
        end
    endtask

    task automatic test_load_use();
        stim_t st[$];
        logic [15:0] ex[$];
        logic [15:0] got, want;
        st.push_back(S(2,7,0, 0,0, 7, 0,0, 0,0, 1,0,0, 0)); ex.push_back(E(0,1,1,0,1,0,0,0,0));
        st.push_back(S(2,7,0, 0,0, 7, 0,0, 0,0, 0,0,0, 0)); ex.push_back(E(0,0,0,0,0,0,0,0,0));
        st.push_back(S(0,0,0, 0,0, 0, 0,0, 0,0, 1,0,0, 0)); ex.push_back(E(0,0,0,0,0,0,0,0,0));
        st.push_back(S(0,0,0, 0,0, 5, 0,0, 0,0, 1,0,0, 0)); ex.push_back(E(0,0,0,0,0,0,0,0,0));
        st.push_back(S(4,0,0, 0,0, 4, 0,0, 0,0, 1,0,0, 0)); ex.push_back(E(0,1,1,0,1,0,0,0,0));
        st.push_back(S(3,2,0, 0,0, 4, 0,0, 0,0, 1,0,0, 0)); ex.push_back(E(0,0,0,0,0,0,0,0,0));
        for (int k = 0; k < st.size(); k++) begin
            @(negedge clk); apply(st[k]); exp_q.push_back(ex[k]); #2;
            got = obs(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) $display("FAIL load_use[%0d]: got %h want %h", k, got, want);
            else n_pass++;
        end
    endtask

    task automatic test_branch();
        stim_t st[$];
        logic [15:0] ex[$];
        logic [15:0] got, want;
        st.push_back(S(2,7,0, 0,0, 7, 0,0, 0,0, 1,1,0, 0)); ex.push_back(E(0,0,0,1,1,0,0,0,0));
        st.push_back(S(0,0,0, 0,0, 0, 0,0, 0,0, 0,1,0, 0)); ex.push_back(E(0,0,0,1,1,0,0,0,0));
        for (int k = 0; k < st.size(); k++) begin
            @(negedge clk); apply(st[k]); exp_q.push_back(ex[k]); #2;
            got = obs(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) $display("FAIL branch[%0d]: got %h want %h", k, got, want);
            else n_pass++;
        end
    endtask

    task automatic test_md_latency();
        stim_t st[$];
        logic [15:0] ex[$];
        logic [15:0] got, want;
        st.push_back(S(0,0,0, 0,0, 9, 0,0, 0,0, 0,0,1, 0)); ex.push_back(E(0,0,0,0,0,0,0,0,0));
        st.push_back(S(8,0,0, 0,0, 0, 0,0, 0,0, 0,0,0, 0)); ex.push_back(E(0,0,0,0,0,0,0,1,0));
        st.push_back(IDLE());                               ex.push_back(E(0,1,1,0,1,0,0,1,0));
        st.push_back(IDLE());                               ex.push_back(E(0,0,0,0,0,0,0,1,0));
        st.push_back(IDLE());                               ex.push_back(E(0,0,0,0,0,1,9,1,0));
        st.push_back(IDLE());                               ex.push_back(E(0,0,0,0,0,0,0,0,0));
        st.push_back(IDLE());                               ex.push_back(E(0,0,0,0,0,0,0,0,0));
        for (int k = 0; k < st.size(); k++) begin
            @(negedge clk); apply(st[k]); exp_q.push_back(ex[k]); #2;
            got = obs(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) $display("FAIL md_latency[%0d]: got %h want %h", k, got, want);
            else n_pass++;
        end
    endtask

    task automatic test_md_raw();
        stim_t st[$];
        logic [15:0] ex[$];
        logic [15:0] got, want;
        // dependent source register
        st.push_back(S(0,0,0, 0,0, 9, 0,0, 0,0, 0,0,1, 0)); ex.push_back(E(0,0,0,0,0,0,0,0,0));
        for (int c = 0; c < 3; c++) begin
            st.push_back(S(9,0,0, 0,0, 0, 0,0, 0,0, 0,0,0, 0)); ex.push_back(E(0,1,1,0,1,0,0,1,0));
        end
        st.push_back(S(9,0,0, 0,0, 0, 0,0, 0,0, 0,0,0, 0)); ex.push_back(E(0,1,1,0,1,1,9,1,0));
        st.push_back(S(9,0,0, 0,0, 0, 0,0, 0,0, 0,0,0, 0)); ex.push_back(E(0,0,0,0,0,0,0,0,0));
        // second multi-cycle op waiting in D
        st.push_back(S(0,0,0, 0,0, 9, 0,0, 0,0, 0,0,1, 0)); ex.push_back(E(0,0,0,0,0,0,0,0,0));
        for (int c = 0; c < 3; c++) begin
            st.push_back(S(0,0,1, 0,0, 0, 0,0, 0,0, 0,0,0, 0)); ex.push_back(E(0,1,1,0,1,0,0,1,0));
        end
        st.push_back(S(0,0,1, 0,0, 0, 0,0, 0,0, 0,0,0, 0)); ex.push_back(E(0,1,1,0,1,1,9,1,0));
        st.push_back(S(0,0,1, 0,0, 0, 0,0, 0,0, 0,0,0, 0)); ex.push_back(E(0,0,0,0,0,0,0,0,0));
        // destination x0: tracked, slot still reserved, no RAW stall
        st.push_back(S(0,0,0, 0,0, 0, 0,0, 0,0, 0,0,1, 0)); ex.push_back(E(0,0,0,0,0,0,0,0,0));
        st.push_back(S(0,3,0, 0,0, 0, 0,0, 0,0, 0,0,0, 0)); ex.push_back(E(0,0,0,0,0,0,0,1,0));
        st.push_back(S(0,3,0, 0,0, 0, 0,0, 0,0, 0,0,0, 0)); ex.push_back(E(0,1,1,0,1,0,0,1,0));
        st.push_back(S(0,3,0, 0,0, 0, 0,0, 0,0, 0,0,0, 0)); ex.push_back(E(0,0,0,0,0,0,0,1,0));
        st.push_back(S(0,3,0, 0,0, 0, 0,0, 0,0, 0,0,0, 0)); ex.push_back(E(0,0,0,0,0,1,0,1,0));
        st.push_back(IDLE());                               ex.push_back(E(0,0,0,0,0,0,0,0,0));
        for (int k = 0; k < st.size(); k++) begin
            @(negedge clk); apply(st[k]); exp_q.push_back(ex[k]); #2;
            got = obs(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) $display("FAIL md_raw[%0d]: got %h want %h", k, got, want);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        stim_t st[$];
        logic [15:0] ex[$];
        logic [15:0] got, want;
        st.push_back(S(0,0,0, 0,0, 9, 0,0, 0,0, 0,1,1, 0)); ex.push_back(E(0,0,0,1,1,0,0,0,0));
        st.push_back(IDLE());                               ex.push_back(E(0,0,0,0,0,0,0,1,0));
        st.push_back(IDLE());                               ex.push_back(E(0,1,1,0,1,0,0,1,0));
        st.push_back(IDLE());                               ex.push_back(E(0,0,0,0,0,0,0,1,0));
        st.push_back(IDLE());                               ex.push_back(E(0,0,0,0,0,1,9,1,0));
        st.push_back(S(0,0,0, 0,0,11, 0,0, 0,0, 0,0,1, 0)); ex.push_back(E(0,0,0,0,0,0,0,0,0));
        st.push_back(IDLE());                               ex.push_back(E(0,0,0,0,0,0,0,1,0));
        st.push_back(IDLE());                               ex.push_back(E(0,1,1,0,1,0,0,1,0));
        st.push_back(IDLE());                               ex.push_back(E(0,0,0,0,0,0,0,1,0));
        st.push_back(IDLE());                               ex.push_back(E(0,0,0,0,0,1,11,1,0));
        st.push_back(IDLE());                               ex.push_back(E(0,0,0,0,0,0,0,0,0));
        for (int k = 0; k < st.size(); k++) begin
            @(negedge clk); apply(st[k]); exp_q.push_back(ex[k]); #2;
            got = obs(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) $display("FAIL back_to_back[%0d]: got %h want %h", k, got, want);
            else n_pass++;
        end
    endtask

    task automatic test_error();
        stim_t st[$];
        logic [15:0] ex[$];
        logic [15:0] got, want;
        st.push_back(S(0,0,0, 0,0, 9, 0,0, 0,0, 0,0,1, 0)); ex.push_back(E(0,0,0,0,0,0,0,0,0));
        st.push_back(S(0,0,0, 0,0,12, 0,0, 0,0, 0,0,1, 0)); ex.push_back(E(0,0,0,0,0,0,0,1,0));
        st.push_back(IDLE());                               ex.push_back(E(0,1,1,0,1,0,0,1,1));
        st.push_back(IDLE());                               ex.push_back(E(0,0,0,0,0,0,0,1,1));
        st.push_back(IDLE());                               ex.push_back(E(0,0,0,0,0,1,9,1,1));
        st.push_back(IDLE());                               ex.push_back(E(0,0,0,0,0,0,0,0,1));
        for (int k = 0; k < st.size(); k++) begin
            @(negedge clk); apply(st[k]); exp_q.push_back(ex[k]); #2;
            got = obs(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) $display("FAIL error[%0d]: got %h want %h", k, got, want);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midop();
        stim_t st[$];
        logic [15:0] ex[$];
        logic [15:0] got, want;
        st.push_back(S(0,0,0, 0,0, 9, 0,0, 0,0, 0,0,1, 0)); ex.push_back(E(0,0,0,0,0,0,0,0,1));
        st.push_back(S(9,0,0, 0,0, 0, 0,0, 0,0, 0,0,0, 0)); ex.push_back(E(0,1,1,0,1,0,0,1,1));
        st.push_back(S(9,0,0, 5,0, 0, 5,1, 0,0, 0,1,0, 1)); ex.push_back(E(0,0,0,0,0,0,0,0,0));
        for (int c = 0; c < 5; c++) begin
            st.push_back(S(9,0,0, 0,0, 0, 0,0, 0,0, 0,0,0, 0)); ex.push_back(E(0,0,0,0,0,0,0,0,0));
        end
        for (int k = 0; k < st.size(); k++) begin
            @(negedge clk); apply(st[k]); exp_q.push_back(ex[k]); #2;
            got = obs(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) $display("FAIL reset_midop[%0d]: got %h want %h", k, got, want);
            else n_pass++;
        end
    endtask

    initial begin
        apply(IDLE());
        rst = 1'b1;
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_md_latency();
        test_md_raw();
        test_back_to_back();
        test_error();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
